maquina_estados_mascota: RTL

MAQUINA_ESTADOS_MASCOTA -- requirements
Module: maquina_estados_mascota

---
 rtl/mascota_pkg.sv | 43 ++++
 rtl/contador_segundos.sv | 32 +++
 rtl/maquina_estados_mascota.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mascota_pkg.sv
// Shared definitions for the virtual pet state machine: state codes,
// need-level thresholds and small classification helpers.
package mascota_pkg;

  localparam int ESTADO_W = 3;

  localparam logic [1:0] NIVEL_CRITICO = 2'd0;
  localparam logic [1:0] NIVEL_LOW     = 2'd1;
  localparam logic [1:0] NIVEL_LLENO   = 2'd3;

  typedef enum logic [ESTADO_W-1:0] {
    NEUTRAL    = 3'd0,
    HAMBRIENTO = 3'd1,
    CANSADO    = 3'd2,
    TRISTE     = 3'd3,
    ENFERMO    = 3'd4,
    DORMIDO    = 3'd5,
    MUERTO     = 3'd6
  } estado_t;

  function automatic logic es_bajo(input logic [1:0] nivel);
    return (nivel <= NIVEL_LOW);
  endfunction

  function automatic logic es_critico(input logic [1:0] nivel);
    return (nivel == NIVEL_CRITICO);
  endfunction

  // Test-mode stepping order; anything past MUERTO folds back to NEUTRAL.
  function automatic estado_t sig_estado(input estado_t e);
    case (e)
      NEUTRAL:    return HAMBRIENTO;
      HAMBRIENTO: return CANSADO;
      CANSADO:    return TRISTE;
      TRISTE:     return ENFERMO;
      ENFERMO:    return DORMIDO;
      DORMIDO:    return MUERTO;
      MUERTO:     return NEUTRAL;
      default:    return NEUTRAL;
    endcase
  endfunction

endpackage

// File: rtl/contador_segundos.sv
// Free-running divider: registered one-cycle tick every TICK_MAX clocks.
module contador_segundos #(
  parameter int TICK_MAX = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [TW-1:0] TOPE = TW'(TICK_MAX - 1);

  logic [TW-1:0] cnt_r;
  logic          tick_r;

  // Count 0..TICK_MAX-1, raise tick on the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= {TW{1'b0}};
      tick_r <= 1'b0;
    end else if (cnt_r == TOPE) begin
      cnt_r  <= {TW{1'b0}};
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + TW'(1);
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/maquina_estados_mascota.sv
// Pet behaviour FSM: need-driven transitions, starvation/death timer and a
// button-stepped test mode that overrides everything until reset.
module maquina_estados_mascota
  import mascota_pkg::*;
#(
  parameter int TICK_MAX  = 50_000_000,
  parameter int T_CRITICO = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          Nivel_Animo,
  input  logic [1:0]          Nivel_Energia,
  input  logic [1:0]          Nivel_Descanso,
  input  logic [1:0]          Nivel_Medicina,
  input  logic                senal_5segDescanso,
  input  logic                B_Test,
  output logic [ESTADO_W-1:0] Estado,
  output logic                Activo_Comida,
  output logic                Activo_Medicina,
  output logic                Test_activo,
  output logic                Cambio_estado
);

  localparam int CW = $clog2(T_CRITICO + 1);
  localparam logic [CW-1:0] T_CRIT_C = CW'(T_CRITICO);

  estado_t       state_r, prev_r, nxt_s;
  logic          comida_r, med_r, test_r, cambio_r, b_test_r;
  logic [CW-1:0] crit_r;
  logic          tick_s, rise_s, avanza_s, critico_s;

  contador_segundos #(.TICK_MAX(TICK_MAX)) u_segundos (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  assign rise_s    = B_Test & ~b_test_r;
  // A dead pet ignores the button unless test mode was already running.
  assign avanza_s  = rise_s & (test_r | (state_r != MUERTO));
  assign critico_s = es_critico(Nivel_Animo) | es_critico(Nivel_Energia) |
                     es_critico(Nivel_Descanso) | es_critico(Nivel_Medicina);

  // Next-state selection: test edge, then test hold, then death, then needs.
  always_comb begin
    nxt_s = state_r;
    if (state_r > MUERTO) begin
      nxt_s = NEUTRAL;
    end else if (avanza_s) begin
      nxt_s = test_r ? sig_estado(state_r) : HAMBRIENTO;
    end else if (test_r) begin
      nxt_s = state_r;
    end else if ((state_r != MUERTO) && (crit_r == T_CRIT_C)) begin
      nxt_s = MUERTO;
    end else begin
      case (state_r)
        NEUTRAL: begin
          if (es_bajo(Nivel_Medicina))      nxt_s = ENFERMO;
          else if (es_bajo(Nivel_Energia))  nxt_s = HAMBRIENTO;
          else if (es_bajo(Nivel_Descanso)) nxt_s = CANSADO;
          else if (es_bajo(Nivel_Animo))    nxt_s = TRISTE;
          else                              nxt_s = NEUTRAL;
        end
        HAMBRIENTO: begin
          if (es_bajo(Nivel_Medicina))     nxt_s = ENFERMO;
          else if (!es_bajo(Nivel_Energia)) nxt_s = NEUTRAL;
          else                             nxt_s = HAMBRIENTO;
        end
        CANSADO: begin
          if (es_bajo(Nivel_Medicina))       nxt_s = ENFERMO;
          else if (senal_5segDescanso)       nxt_s = DORMIDO;
          else if (!es_bajo(Nivel_Descanso)) nxt_s = NEUTRAL;
          else                               nxt_s = CANSADO;
        end
        TRISTE: begin
          if (es_bajo(Nivel_Medicina))    nxt_s = ENFERMO;
          else if (!es_bajo(Nivel_Animo)) nxt_s = NEUTRAL;
          else                            nxt_s = TRISTE;
        end
        ENFERMO: begin
          if (!es_bajo(Nivel_Medicina)) nxt_s = NEUTRAL;
          else                          nxt_s = ENFERMO;
        end
        DORMIDO: begin
          if (Nivel_Descanso == NIVEL_LLENO) nxt_s = NEUTRAL;
          else                               nxt_s = DORMIDO;
        end
        MUERTO:  nxt_s = MUERTO;
        default: nxt_s = NEUTRAL;
      endcase
    end
  end

  // State, registered enables, change pulse, test flag and critical timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= NEUTRAL;
      prev_r   <= NEUTRAL;
      comida_r <= 1'b1;
      med_r    <= 1'b0;
      test_r   <= 1'b0;
      cambio_r <= 1'b0;
      b_test_r <= 1'b0;
      crit_r   <= {CW{1'b0}};
    end else begin
      b_test_r <= B_Test;
      state_r  <= nxt_s;
      prev_r   <= state_r;
      cambio_r <= (state_r != prev_r);
      comida_r <= (nxt_s == NEUTRAL) || (nxt_s == HAMBRIENTO);
      med_r    <= (nxt_s == ENFERMO);
      test_r   <= test_r | avanza_s;
      if (test_r || avanza_s || !critico_s) begin
        crit_r <= {CW{1'b0}};
      end else if (tick_s && (crit_r != T_CRIT_C)) begin
        crit_r <= crit_r + CW'(1);
      end else begin
        crit_r <= crit_r;
      end
    end
  end

  assign Estado          = state_r;
  assign Activo_Comida   = comida_r;
  assign Activo_Medicina = med_r;
  assign Test_activo     = test_r;
  assign Cambio_estado   = cambio_r;

endmodule
